vm_change_dispenser: RTL and testbench
======================================

# vm_change_dispenser

Consumes the countdown produced by the vending machine's wait timer. When that countdown expires, it returns the customer's outstanding balance as a sequence of physical coins. Each coin goes to the coin hopper over a valid/ready handshake, largest denomination first. The block sits between the timer, the balance datapath and the hopper; it tells the datapath when the balance must be cleared.

## Interface
Parameters:
- BAL_W, 31: width of balance and remainder values
- COIN0_VAL, 100: value of coin index 0 (smallest)
- COIN1_VAL, 500: value of coin index 1
- COIN2_VAL, 1000: value of coin index 2 (largest)

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- i_wait_time  in  32  timer countdown value
- i_balance  in  BAL_W  current customer balance; sampled only at the start event
- i_hopper_ready  in  1  hopper accepts the presented coin at this edge
- o_return_coin  out  `kNumCoins  one-hot coin presented to the hopper; 0 = none
- o_busy  out  1  high from start event until the o_done cycle inclusive; top level blocks coin input and item selection while high
- o_done  out  1  one-cycle pulse; datapath clears balance
- o_remainder  out  BAL_W  value that could not be returned as coins; valid while o_done is high

## Operation
- Start event: at a posedge, all of the following hold:
  - i_wait_time == 0
  - registered prev_nonzero == 1, where prev_nonzero is the previous cycle's (i_wait_time != 0)
  - state == IDLE
  - i_balance != 0
- If i_balance == 0 at the 1→0 transition, no action and no o_done.
- States:
  - IDLE: waits for the start event. On the start event, remaining <= i_balance and the state goes to DISPENSE.
  - DISPENSE: presents coin k, the largest index with COINk_VAL <= remaining.
    - If i_hopper_ready == 1 at the edge, remaining <= remaining - COINk_VAL.
    - If remaining < COIN0_VAL, no coin is presented (o_return_coin = 0) and the state goes to DONE.
  - DONE: o_done = 1 and o_remainder = remaining for exactly one cycle, then IDLE.
- o_return_coin is decoded from state and remaining only. There is no combinational path from any input to any output.
- Exactly one bit of o_return_coin is set in DISPENSE when a coin is presented; the vector is 0 in all other states.
- Handshake: a coin is transferred only on an edge where o_return_coin != 0 and i_hopper_ready == 1. While ready is low, o_return_coin stays stable.
- Inputs ignored while busy:
  - i_balance changes after the start event are ignored.
  - A timer reload (i_wait_time going nonzero) during DISPENSE or DONE does not abort or restart dispensing.
  - prev_nonzero keeps tracking on every edge.
- Arithmetic: remaining is BAL_W unsigned. The subtraction cannot underflow because coin selection guarantees COINk_VAL <= remaining. Comparisons are unsigned.

## Timing
- Reset values:
  - state = IDLE, remaining = 0, prev_nonzero = 0
  - o_return_coin = 0, o_busy = 0, o_done = 0, o_remainder = 0
- Reset mid-operation: everything returns immediately to the values above. A coin presented but not yet accepted is dropped, with no o_done.
- Because prev_nonzero resets to 0, a wait time that is 0 out of reset does not trigger a start.
- Latency:
  - Start event at edge k → first coin visible in the cycle after edge k.
  - Throughput is one coin per cycle while ready is held high.
  - Last accepted coin at edge m → DONE entered at edge m+1 → o_done high during cycle m+1..m+2 → IDLE at edge m+2.
- A start event is not possible while o_busy is high. The next start needs a fresh nonzero→0 transition of i_wait_time after returning to IDLE.

## Structure
- Shared definitions go in vending_machine_def.v, alongside the existing `kNumCoins, `kNumItems and `kWaitTime:
  - state encodings `kDispIdle, `kDispDispense, `kDispDone
  - default coin values
- One sub-module is natural: vm_coin_select, a combinational block mapping remaining to a one-hot coin index plus its value.
- The FSM, remaining register and edge detector live in vm_change_dispenser.

## Test plan
- Balance 1700, timer 3→0, ready held 1:
  - coins 1000, 500, 100, 100 on consecutive cycles
  - o_done one cycle later with o_remainder 0
  - o_busy drops after the done cycle
- Balance 600 with ready low for 3 cycles on the first coin:
  - o_return_coin holds 500 stable for 3 cycles; remaining does not change
  - then 500, 100, o_done, remainder 0
- Balance 650:
  - 500, 100, then o_done with o_remainder 50
- Balance 0 at timer expiry: no coin, no o_done, o_busy stays 0.
- Reset asserted while a 1000 coin is presented with ready low:
  - outputs go to 0 asynchronously
  - after release with i_wait_time held at 0, no dispensing occurs
- Timer reloaded to `kWaitTime+1 mid-dispense: dispensing completes unchanged. A new start requires the timer to count down to 0 again after IDLE.

Source files
------------

// File: rtl/vm_change_dispenser_pkg.sv
// Shared definitions for the change dispenser: coin count, timer reload value,
// default coin denominations and dispenser FSM state encodings.
package vm_change_dispenser_pkg;

  localparam int K_NUM_COINS = 3;
  localparam int K_WAIT_TIME = 10;

  localparam int K_COIN0_VAL = 100;
  localparam int K_COIN1_VAL = 500;
  localparam int K_COIN2_VAL = 1000;

  typedef enum logic [1:0] {
    K_DISP_IDLE     = 2'd0,
    K_DISP_DISPENSE = 2'd1,
    K_DISP_DONE     = 2'd2
  } disp_state_e;

endpackage

// File: rtl/vm_coin_select.sv
// Combinational: picks the largest coin whose value fits in the remaining balance.
// Returns a one-hot coin index and that coin's value; zero when nothing fits.
module vm_coin_select
  import vm_change_dispenser_pkg::*;
#(
  parameter int BAL_W     = 31,
  parameter int COIN0_VAL = K_COIN0_VAL,
  parameter int COIN1_VAL = K_COIN1_VAL,
  parameter int COIN2_VAL = K_COIN2_VAL
) (
  input  logic [BAL_W-1:0]       i_remaining,
  output logic [K_NUM_COINS-1:0] o_coin,
  output logic [BAL_W-1:0]       o_coin_val
);

  always_comb begin
    o_coin     = '0;
    o_coin_val = '0;
    if (i_remaining >= BAL_W'(COIN2_VAL)) begin
      o_coin     = 3'b100;
      o_coin_val = BAL_W'(COIN2_VAL);
    end else if (i_remaining >= BAL_W'(COIN1_VAL)) begin
      o_coin     = 3'b010;
      o_coin_val = BAL_W'(COIN1_VAL);
    end else if (i_remaining >= BAL_W'(COIN0_VAL)) begin
      o_coin     = 3'b001;
      o_coin_val = BAL_W'(COIN0_VAL);
    end
  end

endmodule

// File: rtl/vm_change_dispenser.sv
// Returns the outstanding balance as coins, largest first, once the wait timer
// expires; one coin per accepted hopper handshake, then a one-cycle done pulse.
module vm_change_dispenser
  import vm_change_dispenser_pkg::*;
#(
  parameter int BAL_W     = 31,
  parameter int COIN0_VAL = K_COIN0_VAL,
  parameter int COIN1_VAL = K_COIN1_VAL,
  parameter int COIN2_VAL = K_COIN2_VAL
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            i_wait_time,
  input  logic [BAL_W-1:0]       i_balance,
  input  logic                   i_hopper_ready,
  output logic [K_NUM_COINS-1:0] o_return_coin,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [BAL_W-1:0]       o_remainder
);

  disp_state_e             r_state;
  logic [BAL_W-1:0]        r_remaining;
  logic                    r_prev_nonzero;
  logic                    r_busy;
  logic                    r_done;
  logic [BAL_W-1:0]        r_remainder;

  logic [K_NUM_COINS-1:0]  w_coin;
  logic [BAL_W-1:0]        w_coin_val;
  logic                    w_start;

  vm_coin_select #(
    .BAL_W     (BAL_W),
    .COIN0_VAL (COIN0_VAL),
    .COIN1_VAL (COIN1_VAL),
    .COIN2_VAL (COIN2_VAL)
  ) u_coin_select (
    .i_remaining (r_remaining),
    .o_coin      (w_coin),
    .o_coin_val  (w_coin_val)
  );

  // Falling edge of the timer only; a zero balance at expiry is a no-op.
  assign w_start = (i_wait_time == 32'd0) && r_prev_nonzero &&
                   (r_state == K_DISP_IDLE) && (i_balance != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= K_DISP_IDLE;
      r_remaining    <= '0;
      r_prev_nonzero <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_remainder    <= '0;
    end else begin
      r_prev_nonzero <= (i_wait_time != 32'd0);
      case (r_state)
        K_DISP_IDLE: begin
          if (w_start) begin
            r_remaining <= i_balance;
            r_busy      <= 1'b1;
            r_state     <= K_DISP_DISPENSE;
          end
        end
        K_DISP_DISPENSE: begin
          if (w_coin == '0) begin
            r_done      <= 1'b1;
            r_remainder <= r_remaining;
            r_state     <= K_DISP_DONE;
          end else if (i_hopper_ready) begin
            r_remaining <= r_remaining - w_coin_val;
          end
        end
        K_DISP_DONE: begin
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_remainder <= '0;
          r_state     <= K_DISP_IDLE;
        end
        default: begin
          r_state <= K_DISP_IDLE;
        end
      endcase
    end
  end

  assign o_return_coin = (r_state == K_DISP_DISPENSE) ? w_coin : '0;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_remainder   = r_remainder;

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Bench for vm_change_dispenser: directed scenarios plus randomized balances,
// hopper stalls and timer reloads checked against a greedy coin-list model.
module tb_vm_change_dispenser;
  import vm_change_dispenser_pkg::*;

  localparam int BAL_W = 31;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [31:0]            i_wait_time;
  logic [BAL_W-1:0]       i_balance;
  logic                   i_hopper_ready;
  logic [K_NUM_COINS-1:0] o_return_coin;
  logic                   o_busy;
  logic                   o_done;
  logic [BAL_W-1:0]       o_remainder;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vm_change_dispenser #(.BAL_W(BAL_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_wait_time    (i_wait_time),
    .i_balance      (i_balance),
    .i_hopper_ready (i_hopper_ready),
    .o_return_coin  (o_return_coin),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_remainder    (o_remainder)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int coin_value(input int k);
    case (k)
      0:       return 100;
      1:       return 500;
      default: return 1000;
    endcase
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_coin"}, 64'(o_return_coin), 64'd0);
    chk({tag, "_done"}, 64'(o_done), 64'd0);
  endtask

  task automatic start_timer(input int bal);
    i_balance   = BAL_W'(bal);
    i_wait_time = 32'd3;
    tick();
    i_wait_time = 32'd2;
    tick();
    i_wait_time = 32'd1;
    tick();
    chk("pre_start_busy", 64'(o_busy), 64'd0);
    i_wait_time = 32'd0;
    tick();
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready low for first 3 cycles
  task automatic run_txn(input int bal, input int mode, input bit reload);
    int q[$];
    int rem;
    int cyc;
    int popped;
    bit rdy;
    rem = bal;
    for (int k = 2; k >= 0; k--) begin
      while (rem >= coin_value(k)) begin
        q.push_back(k);
        rem -= coin_value(k);
      end
    end
    start_timer(bal);
    if (bal == 0) begin
      repeat (3) begin
        check_idle("zero_bal");
        tick();
      end
      return;
    end
    cyc = 0;
    while (q.size() > 0 && cyc < 200) begin
      chk("coin", 64'(o_return_coin), 64'(1 << q[0]));
      chk("coin_busy", 64'(o_busy), 64'd1);
      chk("coin_done", 64'(o_done), 64'd0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (cyc >= 3);
      endcase
      i_hopper_ready = rdy;
      i_balance      = BAL_W'($urandom);
      if (reload && cyc == 1) i_wait_time = 32'(K_WAIT_TIME + 1);
      tick();
      if (rdy) popped = q.pop_front();
      cyc++;
    end
    if (q.size() != 0) chk("coin_budget", 64'(q.size()), 64'd0);
    i_hopper_ready = 1'($urandom_range(0, 1));
    chk("drain_coin", 64'(o_return_coin), 64'd0);
    chk("drain_busy", 64'(o_busy), 64'd1);
    chk("drain_done", 64'(o_done), 64'd0);
    tick();
    chk("done_pulse", 64'(o_done), 64'd1);
    chk("done_rem", 64'(o_remainder), 64'(rem));
    chk("done_busy", 64'(o_busy), 64'd1);
    chk("done_coin", 64'(o_return_coin), 64'd0);
    tick();
    chk("post_done", 64'(o_done), 64'd0);
    chk("post_busy", 64'(o_busy), 64'd0);
    chk("post_rem", 64'(o_remainder), 64'd0);
    i_hopper_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n        = 1'b0;
    i_wait_time    = 32'd0;
    i_balance      = '0;
    i_hopper_ready = 1'b0;
    #12;
    check_idle("reset");
    chk("reset_rem", 64'(o_remainder), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    i_balance = BAL_W'(700);
    repeat (3) begin
      tick();
      check_idle("zero_timer_oor");
    end

    run_txn(1700, 0, 1'b0);
    run_txn(600, 2, 1'b0);
    run_txn(650, 0, 1'b0);
    run_txn(0, 0, 1'b0);
    run_txn(99, 0, 1'b0);
    run_txn(100, 0, 1'b0);

    // Reset while a 1000 coin is stalled at the hopper.
    i_hopper_ready = 1'b0;
    start_timer(1000);
    chk("rst_pre_coin", 64'(o_return_coin), 64'd4);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle("rst_async");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      tick();
      check_idle("rst_after");
    end

    // Timer reload mid-dispense, then no restart while the timer stays nonzero.
    run_txn(1700, 0, 1'b1);
    repeat (3) begin
      tick();
      check_idle("reload_idle");
    end

    repeat (20) begin
      run_txn($urandom_range(0, 4000), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
